serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Parametrised multi-cycle adder/subtractor; successor to the single-bit half adder.
//   Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB first, through one DIGIT-bit carry chain.
//   Valid/ready handshake on input and output; sits between operand producer and result consumer.
//   One operation in flight at a time.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; >= 2
//   DIGIT  1  bits processed per clock; >= 1, WIDTH % DIGIT == 0; STEPS = WIDTH/DIGIT
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands/op presented
//   in_ready   out  1      block can accept an operation
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in; ignored when sub=1
//   sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result bits
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//   Reset (rst=1 at an edge): state<=IDLE, step count<=0, sum<=0, cout<=0, ovf<=0, out_valid<=0.
//     in_ready forced 0 while rst high; reset wins over every other event, including mid-RUN/DONE.
//   FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE) & ~rst; out_valid = (state==DONE).
//   IDLE: on in_valid & in_ready edge (accept): latch a, b^{WIDTH{sub}}, carry <= sub ? 1 : cin;
//     count <= 0; -> RUN. No accept -> stay IDLE, registers unchanged.
//   RUN: each edge adds digit [count*DIGIT +: DIGIT] of latched operands with carry;
//     digit result shifted into sum from MSB side (sum ends in natural bit order);
//     carry register updated; count++. On edge where count == STEPS-1: record carry into MSB
//     and carry out, set cout/ovf -> DONE.
//   Latency: out_valid high exactly STEPS cycles after the accept edge (DIGIT=1,WIDTH=8: 8 cycles).
//   DONE: sum/cout/ovf held stable while out_valid=1 & out_ready=0 (backpressure, unlimited).
//     On out_valid & out_ready edge -> IDLE; in_ready rises next cycle (no same-cycle accept).
//     sum/cout/ovf retain last result in IDLE/RUN until overwritten at next DONE entry.
//   Input port values after accept are ignored; in_valid while not in_ready is not an accept.
//   Arithmetic is modulo 2^WIDTH; no saturation. Throughput: one op per STEPS+2 cycles max.
//   DIGIT == WIDTH: single RUN cycle; identical function.
// TESTING (WIDTH=8 unless noted)
//   1. DIGIT=1: a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, ovf=0; out_valid 8 cycles after accept.
//   2. a=8'h7F, b=8'h01, cin=0, sub=0 -> sum=8'h80, cout=0, ovf=1; a=8'h10,b=8'h20,cin=1 -> 8'h31, cout=0.
//   3. sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0; a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
//   4. Backpressure: out_ready=0 for 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0; in_valid
//      toggled with new operands during RUN/DONE -> ignored; result matches first op.
//   5. Reset asserted mid-RUN (after 3 steps) -> next edge out_valid=0, sum=0, in_ready=1 after rst
//      drops; following op 8'h12+8'h34 -> 8'h46 with full latency.
//   6. DIGIT=4 and DIGIT=8: exhaustive 4-bit-stride sweep vs a+b+cin model; latency 2 and 1 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock,
// LSB first, through one DIGIT-bit carry chain, with valid/ready on both sides.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout, dig_cmsb, chain;
    logic [WIDTH-1:0] dig_ext;

    always_comb begin
        chain    = carry_q;
        dig_cmsb = carry_q;
        dig_sum  = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            dig_cmsb   = chain;
            dig_sum[i] = a_q[i] ^ b_q[i] ^ chain;
            chain      = (a_q[i] & b_q[i]) | (chain & (a_q[i] ^ b_q[i]));
        end
        dig_cout = chain;
        dig_ext  = '0;
        dig_ext[DIGIT-1:0] = dig_sum;
    end

    // Partial results build up in acc_q so sum keeps the previous result until DONE entry.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = (acc_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
                carry_d = dig_cout;
                count_d = count_q + CW'(1);
                if (count_q == CW'(STEPS - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = dig_cout;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT=1/4/8 instances checked against an arithmetic
// reference model with directed, random and swept operations.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       cin, sub;
    logic       in_valid  [3];
    logic       out_ready [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic [7:0] sum       [3];
    logic       cout      [3];
    logic       ovf       [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_adder #(
            .WIDTH(8),
            .DIGIT((g == 0) ? 1 : ((g == 1) ? 4 : 8))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .sum      (sum[g]),
            .cout     (cout[g]),
            .ovf      (ovf[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as given.
    task automatic model(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s,
                         output logic [7:0] es, output logic ec, output logic eo);
        int u, sv, bu, bs, ci;
        ci = s ? 1 : int'(c);
        bu = s ? (255 - int'(y)) : int'(y);
        bs = (bu > 127) ? bu - 256 : bu;
        u  = int'(x) + bu + ci;
        sv = ((x > 127) ? int'(x) - 256 : int'(x)) + bs + ci;
        es = u[7:0];
        ec = u[8];
        eo = (sv > 127) || (sv < -128);
    endtask

    task automatic noise(input int k);
        in_valid[k] = 1'($urandom_range(0, 1));
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input int k, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic ts, input bit bp);
        int n, steps;
        logic [7:0] es;
        logic ec, eo;
        steps = (k == 0) ? 8 : ((k == 1) ? 2 : 1);
        model(ta, tb, tc, ts, es, ec, eo);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready[k]), 32'd1);
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid[k]  = 1'b1;
        out_ready[k] = !bp;
        @(negedge clk);
        in_valid[k] = 1'b0;
        n = 0;
        while (!out_valid[k] && n < 40) begin
            if (bp) noise(k);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(steps));
        chk("sum",  32'(sum[k]),  32'(es));
        chk("cout", 32'(cout[k]), 32'(ec));
        chk("ovf",  32'(ovf[k]),  32'(eo));
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                noise(k);
                @(negedge clk);
                chk("bp_valid", 32'(out_valid[k]), 32'd1);
                chk("bp_ready", 32'(in_ready[k]),  32'd0);
                chk("bp_sum",   32'(sum[k]),       32'(es));
                chk("bp_flags", {30'd0, cout[k], ovf[k]}, {30'd0, ec, eo});
            end
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        @(negedge clk);
        chk("valid_drop", 32'(out_valid[k]), 32'd0);
        chk("ready_back", 32'(in_ready[k]),  32'd1);
    endtask

    initial begin
        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_sum",       32'(sum[0]),       32'd0);
        chk("rst_flags",     {30'd0, cout[0], ovf[0]}, 32'd0);
        chk("rst_in_ready",  32'(in_ready[0]),  32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(in_ready[0]), 32'd1);

        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
        run_op(0, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1);
        run_op(0, 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b1);
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 8'hA5; b = 8'h3C; cin = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid[0]), 32'd0);
        chk("midrst_sum",   32'(sum[0]),       32'd0);
        chk("midrst_flags", {30'd0, cout[0], ovf[0]}, 32'd0);
        chk("midrst_ready", 32'(in_ready[0]),  32'd0);
        rst = 1'b0;
        #1 chk("midrst_ready_back", 32'(in_ready[0]), 32'd1);
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++)
            run_op(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);

        for (int k = 1; k < 3; k++) begin
            for (int x = 0; x < 256; x += 17)
                for (int y = 0; y < 256; y += 17)
                    for (int m = 0; m < 4; m++)
                        run_op(k, 8'(x), 8'(y), m[0], m[1], 1'b0);
            for (int i = 0; i < 20; i++)
                run_op(k, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
